// File: rtl/load_store_unit.sv
// Data-memory access stage: one load/store per handshake, byte/half/word lanes, fault on bad size/alignment.
// Latency: 2 cycles for good requests (ACCESS then RESP), 1 cycle for faulting requests.
// Backpressure: req_ready drops during ACCESS; responses are single-cycle pulses with no backpressure.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_*               request channel (valid/ready), byte address, right-justified store data
//   resp_valid/_rdata/_fault  one-cycle completion, extended load data, reject flag
//   dmem_*, byte_en     word-addressed ram port; dmem_data driven only for a store in ACCESS
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    inout  wire  [DATA_WIDTH-1:0] dmem_data,
    output logic                  dmem_wen,
    output logic [3:0]            byte_en
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t                  state_q, state_d;
    logic                    we_q;
    logic [1:0]              size_q;
    logic                    unsigned_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    fault_q;

    logic                    accept;
    logic                    req_fault;
    logic                    in_access;
    logic [DATA_WIDTH-1:0]   store_lanes;
    logic [DATA_WIDTH-1:0]   byte_shift;
    logic [DATA_WIDTH-1:0]   half_shift;
    logic [DATA_WIDTH-1:0]   load_val;

    // Ready is gated by rst so nothing is accepted while reset is held.
    assign req_ready = !rst && (state_q != ACCESS);
    assign accept    = req_valid && req_ready;

    always_comb begin
        req_fault = 1'b0;
        case (req_size)
            SIZE_BYTE: req_fault = 1'b0;
            SIZE_HALF: req_fault = req_addr[0];
            SIZE_WORD: req_fault = (req_addr[1:0] != 2'b00);
            default:   req_fault = 1'b1;
        endcase
    end

    // Next-state: IDLE and RESP behave identically on a new accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    state_d = req_fault ? RESP : ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_access = (state_q == ACCESS);

    // Memory-side drive is purely combinational from state so reset removes it at once.
    always_comb begin
        byte_en     = 4'b0000;
        store_lanes = wdata_q;
        case (size_q)
            SIZE_BYTE: begin
                byte_en     = 4'b0001 << addr_q[1:0];
                store_lanes = {4{wdata_q[7:0]}};
            end
            SIZE_HALF: begin
                byte_en     = addr_q[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{wdata_q[15:0]}};
            end
            default: begin
                byte_en     = 4'b1111;
                store_lanes = wdata_q;
            end
        endcase
        if (!in_access) begin
            byte_en = 4'b0000;
        end
    end

    assign dmem_wen  = in_access && we_q;
    assign dmem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_data = dmem_wen ? store_lanes : {DATA_WIDTH{1'bz}};

    // Load alignment: move the addressed lane down to bit 0, then extend.
    always_comb begin
        byte_shift = dmem_data >> {addr_q[1:0], 3'b000};
        half_shift = dmem_data >> {addr_q[1], 4'b0000};
        case (size_q)
            SIZE_BYTE: load_val = unsigned_q ? {24'd0, byte_shift[7:0]}
                                             : {{24{byte_shift[7]}}, byte_shift[7:0]};
            SIZE_HALF: load_val = unsigned_q ? {16'd0, half_shift[15:0]}
                                             : {{16{half_shift[15]}}, half_shift[15:0]};
            default:   load_val = dmem_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            size_q     <= SIZE_BYTE;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                fault_q    <= req_fault;
                if (req_fault) begin
                    rdata_q <= '0;
                end
            end
            if (in_access) begin
                rdata_q <= we_q ? '0 : load_val;
            end
        end
    end

    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage between the cpu execute stage and the data ram. Accepts one load/store request per valid/ready handshake, drives the ram's word-addressed port (dmem_addr, bidirectional dmem_data, dmem_wen, byte_en), and returns an aligned, sign/zero-extended load result or store completion. Misaligned and illegal-size requests are rejected with a fault and never reach memory.

## Interface
- ADDR_WIDTH, 32, address width of request and dmem_addr
- DATA_WIDTH, 32, data word width; only 32 is supported
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and faults
- resp_fault  out  1  qualifies resp_valid: request rejected
- dmem_addr  out  ADDR_WIDTH  word address, bits [1:0] always 0
- dmem_data  inout  DATA_WIDTH  driven only during a store ACCESS cycle, else high-Z
- dmem_wen  out  1  ram write enable
- byte_en  out  4  ram byte-lane enables

## Operation
- States: IDLE, ACCESS, RESP. Reset enters IDLE.
- Accept = req_valid && req_ready; req_ready = 1 in IDLE and RESP, 0 in ACCESS and while rst is high.
- On accept, latch we/size/unsigned/addr/wdata. Fault check: size 11; half with addr[0]=1; word with addr[1:0]!=0.
- Accept without fault -> ACCESS; accept with fault -> RESP with fault flag set, no dmem activity.
- ACCESS -> RESP unconditionally. RESP -> ACCESS or RESP on a new accept, else IDLE.
- byte_en in ACCESS: byte = 0001 << addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111. Outside ACCESS byte_en = 0000.
- Store lanes: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata. dmem_wen = 1 only in ACCESS for stores.
- Loads: ram read is combinational; dmem_data sampled at the end of ACCESS. Byte = word >> 8*addr[1:0], half = word >> 16*addr[1], then extend from bit 7/15 per req_unsigned.
- resp_rdata/resp_fault held registered; meaningful only while resp_valid.

## Timing
- Reset values (asynchronous): state IDLE, req_ready 0 during rst, resp_valid 0, resp_rdata 0, resp_fault 0, dmem_addr 0, dmem_wen 0, byte_en 0000, dmem_data high-Z.
- Good request accepted at edge E0: ACCESS during E0-E1 (ram write commits at E1), resp_valid high during E1-E2. Latency 2 cycles.
- Faulting request accepted at E0: resp_valid and resp_fault high during E0-E1. Latency 1.
- Back-to-back: accept during RESP gives sustained throughput of one request per 2 cycles; fault-only streams run one per cycle.
- resp_valid is exactly one cycle; there is no response backpressure.
- Reset asserted during ACCESS: dmem_wen, byte_en, dmem_data drop immediately; write is not guaranteed; no response issued.
- Reset asserted during RESP: resp_valid drops immediately; the response is lost.
- req fields are ignored whenever req_ready = 0.

## Test plan
- Store word 0xDEADBEEF to 0x100, then load word 0x100 -> during ACCESS byte_en=1111, dmem_wen=1, dmem_addr=0x100; load resp_rdata=0xDEADBEEF, resp_fault=0, two cycles after accept.
- Store byte 0x80 to 0x103, load byte signed 0x103 and unsigned 0x103 -> byte_en=1000, dmem_data=0x80808080; resp_rdata 0xFFFFFF80 then 0x00000080; other bytes of 0x100 unchanged.
- Store half 0x1234 to 0x106, load half signed 0x106 -> byte_en=1100, dmem_addr=0x104; resp_rdata=0x00001234.
- Load half at 0x101, store word at 0x102, size 11 at 0x0 -> each gives resp_fault=1, resp_rdata=0 one cycle after accept; dmem_wen and byte_en stay 0.
- Hold req_valid with three consecutive loads -> req_ready pattern 1,0,1,0,1; resp_valid pulses every other cycle with correct data, no dropped request.
- Assert rst mid-ACCESS of a store -> dmem_wen and byte_en fall same cycle, dmem_data high-Z, no resp_valid; after release, req_ready=1 and state IDLE.
